// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Holds the transmit FSM state encoding and the cfg_parity field encoding.
package uart_pkg;

    // Transmit FSM states; PARITY is only reachable when parity support is compiled in.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // cfg_parity encoding; 2'b11 is treated the same as PAR_NONE.
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART transmitter.
// The head word is presented combinationally on pop_data_o; the transmitter
// spends one IDLE (or final STOP) cycle popping it, which absorbs the read latency.
// full_o is registered so the upstream ready never depends on the same-cycle pop.
module uart_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               pop_data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          full_q, full_d;

    // Next pointer / occupancy values from this cycle's push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_i) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_i && !pop_i) begin
            level_d = level_q + LW'(1);
        end else if (!push_i && pop_i) begin
            level_d = level_q - LW'(1);
        end
        full_d = (level_d == LW'(DEPTH));
    end

    // Pointer, occupancy and full flag registers; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
        end
    end

    // Storage array; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter: queues words from a valid/ready stream and
// serialises them LSB first with start bit, optional parity and 1 or 2 stop bits.
// Compile-time option: UART_TX_PARITY_EN enables the PARITY state and honours
// cfg_parity; without it frames never carry a parity bit and cfg_parity is ignored.
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_ready is !full from a register, so a pop only re-opens it one cycle later.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              cfg_divider,
    input  logic                          cfg_stop2,
    input  logic [1:0]                    cfg_parity,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    output logic                          in_ready,
    output logic                          ser_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          bit_tick
);

    localparam int BIT_W = $clog2(DATA_W + 1);

    tx_state_e         state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              stop2_q, stop2_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              push;
    logic              pop;
    logic              tick;

`ifdef UART_TX_PARITY_EN
    logic              par_en_q, par_en_d;
    logic              par_bit_q, par_bit_d;
`else
    logic              unused_cfg_parity;
    assign unused_cfg_parity = ^cfg_parity;
`endif

    assign push = in_valid && in_ready;

    uart_tx_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (in_data),
        .pop_i       (pop),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level)
    );

    // Bit period ends when the baud counter reaches the divider latched for this frame.
    assign tick = (state_q != IDLE) && (cnt_q == div_q);

    // Next-state logic: FSM, baud counter, bit counter, shifter and frame config latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        stop2_d = stop2_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_W'(DATA_W - 1)) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? PARITY : STOP;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    bit_d   = '0;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (stop2_q && (bit_q == '0)) begin
                        bit_d = BIT_W'(1);
                    end else if (!fifo_empty) begin
                        // Chain straight into the next frame with no idle gap.
                        pop     = 1'b1;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Frame entry: take the head word and freeze the configuration for this frame.
        if (pop) begin
            cnt_d   = '0;
            bit_d   = '0;
            shift_d = fifo_head;
            div_d   = cfg_divider;
            stop2_d = cfg_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_d  = (cfg_parity == PAR_EVEN) || (cfg_parity == PAR_ODD);
            par_bit_d = (cfg_parity == PAR_ODD) ? ~^fifo_head : ^fifo_head;
`endif
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            stop2_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            stop2_q <= stop2_d;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
`endif
        end
    end

    // Line driver: decoded from registered state only, idle/stop level is high.
    always_comb begin
        ser_tx = 1'b1;
        case (state_q)
            START:   ser_tx = 1'b0;
            DATA:    ser_tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  ser_tx = par_bit_q;
`endif
            default: ser_tx = 1'b1;
        endcase
    end

    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || (fifo_level != '0);
    assign bit_tick = tick;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered: an 8-bit/depth-16 instance and a
// 5-bit/depth-4 instance share clock and reset. Inputs change and outputs are
// sampled on the falling edge.
module tb_uart_tx_buffered;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    // 8-bit instance
    logic [15:0] div8;
    logic        stop2_8;
    logic [1:0]  par8;
    logic        valid8;
    logic [7:0]  data8;
    logic        ready8, tx8, busy8, tick8;
    logic [4:0]  level8;

    // 5-bit instance
    logic [15:0] div5;
    logic        stop2_5;
    logic [1:0]  par5;
    logic        valid5;
    logic [4:0]  data5;
    logic        ready5, tx5, busy5, tick5;
    logic [2:0]  level5;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] exp_q[$];

    uart_tx_buffered #(.DATA_W(8), .FIFO_DEPTH(16), .DIV_W(16)) dut8 (
        .clk(clk), .reset(reset), .cfg_divider(div8), .cfg_stop2(stop2_8),
        .cfg_parity(par8), .in_valid(valid8), .in_data(data8), .in_ready(ready8),
        .ser_tx(tx8), .busy(busy8), .fifo_level(level8), .bit_tick(tick8)
    );

    uart_tx_buffered #(.DATA_W(5), .FIFO_DEPTH(4), .DIV_W(16)) dut5 (
        .clk(clk), .reset(reset), .cfg_divider(div5), .cfg_stop2(stop2_5),
        .cfg_parity(par5), .in_valid(valid5), .in_data(data5), .in_ready(ready5),
        .ser_tx(tx5), .busy(busy5), .fifo_level(level5), .bit_tick(tick5)
    );

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total_cnt++;
        if (tx8 !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx8); else pass_cnt++;
        total_cnt++;
        if (ready8 !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready8); else pass_cnt++;
        total_cnt++;
        if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy8); else pass_cnt++;
        total_cnt++;
        if (level8 !== 5'd0) $display("FAIL reset_level: got %0d want 0", level8); else pass_cnt++;
        total_cnt++;
        if (tick8 !== 1'b0) $display("FAIL reset_tick: got %b want 0", tick8); else pass_cnt++;
        total_cnt++;
        if ({tx5, ready5, busy5} !== 3'b110) $display("FAIL reset_dut5: got %b want 110", {tx5, ready5, busy5}); else pass_cnt++;
        reset = 1'b0;
    endtask

    // Push one word into the idle 8-bit instance and check the whole line waveform.
    // bits[0] is the start bit; bits[nbits-1] is the last stop bit.
    task automatic send_check8(input string name, input logic [7:0] data,
                               input logic [15:0] bits, input int nbits, input int div);
        int per;
        per = div + 1;
        @(negedge clk);
        div8   = 16'(div);
        valid8 = 1'b1;
        data8  = data;
        @(negedge clk);
        valid8 = 1'b0;
        total_cnt++;
        if (level8 !== 5'd1) $display("FAIL %s_level: got %0d want 1", name, level8); else pass_cnt++;
        total_cnt++;
        if ({tx8, busy8} !== 2'b11) $display("FAIL %s_pre_start: got tx/busy %b want 11", name, {tx8, busy8}); else pass_cnt++;
        for (int k = 0; k < nbits * per; k++) begin
            @(negedge clk);
            total_cnt++;
            if (tx8 !== bits[k / per]) $display("FAIL %s_line[%0d]: got %b want %b", name, k, tx8, bits[k / per]); else pass_cnt++;
            total_cnt++;
            if (tick8 !== ((k % per) == div)) $display("FAIL %s_tick[%0d]: got %b want %b", name, k, tick8, ((k % per) == div)); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({tx8, busy8, tick8} !== 3'b100) $display("FAIL %s_idle_after: got tx/busy/tick %b want 100", name, {tx8, busy8, tick8}); else pass_cnt++;
    endtask

    task automatic test_single;
        stop2_8 = 1'b0;
        par8    = 2'b00;
        send_check8("a5_8n1", 8'hA5, 16'h034A, 10, 3);
    endtask

    task automatic test_parity;
`ifdef UART_TX_PARITY_EN
        par8 = 2'b01;
        send_check8("par_even", 8'h07, 16'h060E, 11, 1);
        par8 = 2'b10;
        send_check8("par_odd", 8'h07, 16'h040E, 11, 1);
        par8 = 2'b11;
        send_check8("par_11_none", 8'h07, 16'h020E, 10, 1);
`else
        par8 = 2'b01;
        send_check8("par_off_even", 8'h07, 16'h020E, 10, 1);
        par8 = 2'b10;
        send_check8("par_off_odd", 8'h07, 16'h020E, 10, 1);
`endif
        par8 = 2'b00;
    endtask

    // 17 consecutive pushes: first word pops at once, the queue reaches 16 and
    // ready drops. Frame 0 uses divider 20; later frames pick up divider 0.
    task automatic test_fill;
        logic [7:0] w;
        logic [9:0] fr0;
        logic [9:0] fr;
        logic       expb;
        int         rel;
        fr = '1;
        @(negedge clk);
        div8    = 16'd20;
        stop2_8 = 1'b0;
        for (int i = 0; i < 17; i++) begin
            w = 8'(i * 37 + 5);
            total_cnt++;
            if (ready8 !== 1'b1) $display("FAIL fill_ready_push%0d: got %b want 1", i, ready8); else pass_cnt++;
            valid8 = 1'b1;
            data8  = w;
            exp_q.push_back(w);
            @(negedge clk);
        end
        valid8 = 1'b0;
        div8   = 16'd0;
        total_cnt++;
        if (level8 !== 5'd16) $display("FAIL fill_level_full: got %0d want 16", level8); else pass_cnt++;
        total_cnt++;
        if (ready8 !== 1'b0) $display("FAIL fill_ready_low: got %b want 0", ready8); else pass_cnt++;
        w   = exp_q.pop_front();
        fr0 = {1'b1, w, 1'b0};
        for (int j = 17; j <= 371; j++) begin
            if (j <= 211) begin
                expb = fr0[(j - 2) / 21];
            end else begin
                rel = j - 212;
                if ((rel % 10) == 0) begin
                    w  = exp_q.pop_front();
                    fr = {1'b1, w, 1'b0};
                end
                expb = fr[rel % 10];
            end
            total_cnt++;
            if (tx8 !== expb) $display("FAIL fill_line[%0d]: got %b want %b", j, tx8, expb); else pass_cnt++;
            if (j == 212) begin
                total_cnt++;
                if ({ready8, level8} !== {1'b1, 5'd15}) $display("FAIL fill_reopen: got ready/level %b/%0d want 1/15", ready8, level8); else pass_cnt++;
            end
            @(negedge clk);
        end
        total_cnt++;
        if ({busy8, tx8, level8} !== {1'b0, 1'b1, 5'd0}) $display("FAIL fill_drained: got busy/tx/level %b/%b/%0d want 0/1/0", busy8, tx8, level8); else pass_cnt++;
    endtask

    // 5-bit instance: two stop bits at divider 0, divider change mid-frame ignored,
    // then a 5N1 frame at divider 1.
    task automatic test_stop2_w5;
        logic [7:0] bits_a;
        logic [6:0] bits_b;
        bits_a = 8'b1111_1110;
        bits_b = 7'b101_0100;
        @(negedge clk);
        div5    = 16'd0;
        stop2_5 = 1'b1;
        par5    = 2'b00;
        valid5  = 1'b1;
        data5   = 5'h1F;
        @(negedge clk);
        valid5 = 1'b0;
        total_cnt++;
        if ({level5, tx5} !== {3'd1, 1'b1}) $display("FAIL w5_pre: got level/tx %0d/%b want 1/1", level5, tx5); else pass_cnt++;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) div5 = 16'd5;
            total_cnt++;
            if (tx5 !== bits_a[k]) $display("FAIL w5_stop2_line[%0d]: got %b want %b", k, tx5, bits_a[k]); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({busy5, tx5} !== 2'b01) $display("FAIL w5_stop2_end: got busy/tx %b want 01", {busy5, tx5}); else pass_cnt++;
        div5    = 16'd1;
        stop2_5 = 1'b0;
        valid5  = 1'b1;
        data5   = 5'h0A;
        @(negedge clk);
        valid5 = 1'b0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            total_cnt++;
            if (tx5 !== bits_b[k / 2]) $display("FAIL w5_0a_line[%0d]: got %b want %b", k, tx5, bits_b[k / 2]); else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({busy5, tx5} !== 2'b01) $display("FAIL w5_0a_end: got busy/tx %b want 01", {busy5, tx5}); else pass_cnt++;
    endtask

    // Reset in the middle of the DATA bits with three words still queued.
    task automatic test_reset_mid;
        @(negedge clk);
        div8 = 16'd3;
        for (int i = 0; i < 4; i++) begin
            valid8 = 1'b1;
            data8  = 8'(8'h40 + i);
            @(negedge clk);
        end
        valid8 = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({level8, tx8} !== {5'd3, 1'b0}) $display("FAIL rmid_before: got level/tx %0d/%b want 3/0", level8, tx8); else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total_cnt++;
        if ({tx8, ready8, busy8, level8} !== {1'b1, 1'b1, 1'b0, 5'd0}) $display("FAIL rmid_after: got tx/ready/busy/level %b/%b/%b/%0d want 1/1/0/0", tx8, ready8, busy8, level8); else pass_cnt++;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({tx8, busy8} !== 2'b10) $display("FAIL rmid_quiet[%0d]: got tx/busy %b want 10", k, {tx8, busy8}); else pass_cnt++;
        end
    endtask

    initial begin
        reset   = 1'b1;
        div8    = 16'd0;
        stop2_8 = 1'b0;
        par8    = 2'b00;
        valid8  = 1'b0;
        data8   = 8'h00;
        div5    = 16'd0;
        stop2_5 = 1'b0;
        par5    = 2'b00;
        valid5  = 1'b0;
        data5   = 5'h00;
        test_reset();
        test_single();
        test_parity();
        test_fill();
        test_stop2_w5();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
